// File: rtl/led_pattern_player.sv
// Plays LED patterns fetched from the second port of the on-chip RAM.
// Each word carries a 24-bit hold count and an LED field; a hold of 0 marks the end of the table.
module led_pattern_player #(
  parameter int ADDR_W       = 13,
  parameter int LED_W        = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  input  logic [31:0]       mem_readdata,
  output logic [LED_W-1:0]  led_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr
);

  localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(READ_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [23:0]       hold_q, hold_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic              done_q, done_d;
  logic [23:0]       rd_hold;
  logic              unused_rd;

  assign rd_hold   = mem_readdata[31:8];
  assign unused_rd = ^mem_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cur_q   <= '0;
      led_q   <= '0;
      hold_q  <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cur_q   <= cur_d;
      led_q   <= led_d;
      hold_q  <= hold_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cur_d   = cur_q;
    led_d   = led_q;
    hold_d  = hold_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          addr_d  = cfg_base;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (stop) state_d = S_IDLE;
        else begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // readdata is only trusted on the final wait cycle; stop discards the read
        if (stop) state_d = S_IDLE;
        else if (wcnt_q != WAIT_LAST) wcnt_d = wcnt_q + WCW'(1);
        else if (rd_hold != 24'd0) begin
          led_d   = mem_readdata[LED_W-1:0];
          cur_d   = addr_q;
          hold_d  = rd_hold;
          state_d = S_HOLD;
        end else if (loop_en) begin
          addr_d  = cfg_base;
          state_d = S_ISSUE;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (stop) state_d = S_IDLE;
        else if (hold_q == 24'd1) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_ISSUE;
        end else hold_d = hold_q - 24'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = (state_q == S_ISSUE);
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign led_out        = led_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign cur_addr       = cur_q;

endmodule

// File: tb/tb_led_pattern_player.sv
// Scoreboard bench for led_pattern_player: two instances (read latency 1 and 2) share one RAM image.
// Stimulus queues expected fetch/LED/done events with their cycle; a negedge monitor pops and compares.
module tb_led_pattern_player;

  localparam int EV_CS   = 0;
  localparam int EV_LED  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n, start, stop, loop_en, sel;
  logic [12:0] cfg_base;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  ev_t         exp_q[$];
  logic [31:0] mem [0:8191];

  logic [12:0] a_addr, a_cur, b_addr, b_cur, m_addr, m_cur, prev_cur;
  logic        a_cs, a_we, a_busy, a_done, b_cs, b_we, b_busy, b_done, m_cs, m_done;
  logic [3:0]  a_be, b_be;
  logic [7:0]  a_led, b_led, m_led, prev_led;
  logic [31:0] a_rd, b_rd, b_q1;

  led_pattern_player #(.ADDR_W(13), .LED_W(8), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .cfg_base(cfg_base), .mem_address(a_addr), .mem_chipselect(a_cs), .mem_write(a_we),
    .mem_byteenable(a_be), .mem_readdata(a_rd), .led_out(a_led), .busy(a_busy),
    .done(a_done), .cur_addr(a_cur));

  led_pattern_player #(.ADDR_W(13), .LED_W(8), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .cfg_base(cfg_base), .mem_address(b_addr), .mem_chipselect(b_cs), .mem_write(b_we),
    .mem_byteenable(b_be), .mem_readdata(b_rd), .led_out(b_led), .busy(b_busy),
    .done(b_done), .cur_addr(b_cur));

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    a_rd <= mem[a_addr];
    b_q1 <= mem[b_addr];
    b_rd <= b_q1;
  end

  assign m_addr = sel ? b_addr : a_addr;
  assign m_cur  = sel ? b_cur  : a_cur;
  assign m_led  = sel ? b_led  : a_led;
  assign m_cs   = sel ? b_cs   : a_cs;
  assign m_done = sel ? b_done : a_done;

  function automatic logic [31:0] lv(input logic [7:0] led, input logic [12:0] addr);
    return {11'b0, addr, led};
  endfunction

  task automatic push(input int kind, input logic [31:0] val, input int c);
    exp_q.push_back('{kind, val, c});
  endtask

  task automatic check_ev(input int kind, input logic [31:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d val=%h cyc=%0d required=none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        failures++;
        $display("FAIL event actual kind=%0d val=%h cyc=%0d required kind=%0d val=%h cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_cs) check_ev(EV_CS, 32'(m_addr));
      if (m_led != prev_led || m_cur != prev_cur) check_ev(EV_LED, lv(m_led, m_cur));
      if (m_done) check_ev(EV_DONE, 32'd0);
    end
    prev_led = m_led;
    prev_cur = m_cur;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  int s;

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; sel = 1'b0;
    cfg_base = 13'h010;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    repeat (3) tick();
    chk("reset_outputs", {a_led, a_addr, a_cur, a_cs, a_busy, a_done}, '0);
    chk("mem_write_be", {a_we, a_be}, 5'h0F);
    reset_n = 1'b1;

    // T1: single word then END, no loop
    mem[13'h010] = {24'd3, 8'h5A};
    mem[13'h011] = 32'd0;
    tick(); start = 1'b1; s = cyc;
    push(EV_CS, 32'h010, s + 1);
    push(EV_LED, lv(8'h5A, 13'h010), s + 3);
    push(EV_CS, 32'h011, s + 6);
    push(EV_DONE, 32'd0, s + 8);
    tick(); start = 1'b0;
    wait_to(s + 10);
    chk("t1_final", {a_led, a_busy, a_cur}, {8'h5A, 1'b0, 13'h010});

    // T2: same table looping, stopped during a WAIT
    do_reset();
    loop_en = 1'b1;
    tick(); start = 1'b1; s = cyc;
    push(EV_CS, 32'h010, s + 1);
    push(EV_LED, lv(8'h5A, 13'h010), s + 3);
    push(EV_CS, 32'h011, s + 6);
    push(EV_CS, 32'h010, s + 8);
    push(EV_CS, 32'h011, s + 13);
    push(EV_CS, 32'h010, s + 15);
    tick(); start = 1'b0;
    wait_to(s + 16); stop = 1'b1;
    tick(); stop = 1'b0;
    chk("t2_stop_idle", {a_busy, a_cs}, 2'b00);
    wait_to(s + 22);
    chk("t2_led_kept", {a_led, a_cur}, {8'h5A, 13'h010});

    // T3: three words on the latency-2 instance
    reset_n = 1'b0; sel = 1'b1; loop_en = 1'b0;
    mem[13'h010] = {24'd1, 8'h01};
    mem[13'h011] = {24'd1, 8'h02};
    mem[13'h012] = {24'd1, 8'h04};
    mem[13'h013] = 32'd0;
    tick(); reset_n = 1'b1;
    tick(); start = 1'b1; s = cyc;
    push(EV_CS, 32'h010, s + 1);
    push(EV_LED, lv(8'h01, 13'h010), s + 4);
    push(EV_CS, 32'h011, s + 5);
    push(EV_LED, lv(8'h02, 13'h011), s + 8);
    push(EV_CS, 32'h012, s + 9);
    push(EV_LED, lv(8'h04, 13'h012), s + 12);
    push(EV_CS, 32'h013, s + 13);
    push(EV_DONE, 32'd0, s + 16);
    tick(); start = 1'b0;
    wait_to(s + 20);
    reset_n = 1'b0; sel = 1'b0;
    tick(); reset_n = 1'b1;

    // T4: stop mid-HOLD with hold_cnt=100, then replay from base
    mem[13'h010] = {24'd200, 8'h3C};
    mem[13'h011] = 32'd0;
    tick(); start = 1'b1; s = cyc;
    push(EV_CS, 32'h010, s + 1);
    push(EV_LED, lv(8'h3C, 13'h010), s + 3);
    tick(); start = 1'b0;
    wait_to(s + 103); stop = 1'b1;
    tick(); stop = 1'b0;
    chk("t4_stop_idle", {a_busy, a_cs, a_done}, 3'b000);
    wait_to(s + 110);
    chk("t4_frozen", {a_led, a_cur, a_busy}, {8'h3C, 13'h010, 1'b0});
    mem[13'h010] = {24'd1, 8'h3D};
    tick(); start = 1'b1; s = cyc;
    push(EV_CS, 32'h010, s + 1);
    push(EV_LED, lv(8'h3D, 13'h010), s + 3);
    push(EV_CS, 32'h011, s + 4);
    push(EV_DONE, 32'd0, s + 6);
    tick(); start = 1'b0;
    wait_to(s + 10);

    // T5: address wrap from the top of RAM
    cfg_base = 13'h1FFF;
    mem[8191] = {24'd2, 8'hAA};
    mem[0]    = 32'd0;
    tick(); start = 1'b1; s = cyc;
    push(EV_CS, 32'h1FFF, s + 1);
    push(EV_LED, lv(8'hAA, 13'h1FFF), s + 3);
    push(EV_CS, 32'h0000, s + 5);
    push(EV_DONE, 32'd0, s + 7);
    tick(); start = 1'b0;
    wait_to(s + 10);

    // T6: start+stop together, then async reset during WAIT
    cfg_base = 13'h010;
    tick(); start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    repeat (3) tick();
    chk("t6_start_stop", {a_busy, a_cs}, 2'b00);
    start = 1'b1; s = cyc;
    push(EV_CS, 32'h010, s + 1);
    tick(); start = 1'b0;
    wait_to(s + 2);
    chk("t6_in_wait", {a_busy, a_cs}, 2'b10);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_async_reset", {a_led, a_addr, a_cur, a_cs, a_busy, a_done}, '0);
    tick(); reset_n = 1'b1;
    repeat (3) tick();

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_event actual=none required kind=%0d val=%h cyc=%0d", e.kind, e.val, e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
